// File: rtl/hc595_pkg.sv
// Shared constants for the 74HC595 transmit/receive pair.
// The defaults and the counter width helper are used by both sides.
package hc595_pkg;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // bit_cnt has to hold 0..WIDTH+1 so that an overrun stays visible
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchronizer for one asynchronous pin, followed by a rising-edge detector.
// rise is high for one clk cycle, in the cycle where level first reads 1.
module sync_rise
    import hc595_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev;

    // History resets to 0, so a pin already high at reset release shows up as one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev   <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev;

endmodule

// File: rtl/hc595_rx.sv
// Receives a 74HC595-style serial stream (DS/SH_CP/ST_CP) into a parallel word.
// Framing errors are flagged at latch time when the shift count is not WIDTH.
module hc595_rx
    import hc595_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          DS,
    input  logic                          SH_CP,
    input  logic                          ST_CP,
    output logic [WIDTH-1:0]              par_data,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);

    logic                   sh_level;
    logic                   sh_rise;
    logic                   st_level;
    logic                   st_rise;
    logic                   unused_levels;
    logic [SYNC_STAGES-1:0] ds_q;
    logic                   ds_align;
    logic [WIDTH-1:0]       shift_reg;

    sync_rise #(.STAGES(SYNC_STAGES)) u_sh_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SH_CP),
        .level (sh_level),
        .rise  (sh_rise)
    );

    sync_rise #(.STAGES(SYNC_STAGES)) u_st_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ST_CP),
        .level (st_level),
        .rise  (st_rise)
    );

    assign unused_levels = sh_level ^ st_level;

    // Extra flop matches the edge detector's history stage, so data is taken from just before the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_q     <= '0;
            ds_align <= 1'b0;
        end else begin
            ds_q     <= {ds_q[SYNC_STAGES-2:0], DS};
            ds_align <= ds_q[SYNC_STAGES-1];
        end
    end

    // A latch coinciding with a shift stores the pre-shift word and starts the new count at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            par_data    <= '0;
            bit_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= st_rise;
            frame_err   <= st_rise && (bit_cnt != CNT_FULL);
            if (sh_rise) begin
                shift_reg <= {shift_reg[WIDTH-2:0], ds_align};
            end
            if (st_rise) begin
                par_data <= shift_reg;
                bit_cnt  <= sh_rise ? CNT_ONE : '0;
            end else if (sh_rise && (bit_cnt != CNT_MAX)) begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hc595_rx.sv
// Self-checking bench for hc595_rx: fixed frame table, corner sequences, then random frames.
// A word-level model (shift history plus saturating count) predicts every latched frame.
module tb_hc595_rx;

    logic        clk;
    logic        rst_n;
    logic        DS;
    logic        SH_CP;
    logic        ST_CP;
    logic [15:0] par_data;
    logic        frame_valid;
    logic        frame_err;
    logic [4:0]  bit_cnt;

    int n_cmp;
    int n_fail;
    int n_latch;
    int n_valid_seen;

    logic [15:0] m_shift;
    int          m_cnt;

    typedef struct {
        logic [31:0] data;
        int          nbits;
        logic [4:0]  exp_cnt;
        logic [15:0] exp_par;
        logic        exp_err;
    } vec_t;

    vec_t vec [6];

    hc595_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DS          (DS),
        .SH_CP       (SH_CP),
        .ST_CP       (ST_CP),
        .par_data    (par_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .bit_cnt     (bit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst_n && frame_valid) n_valid_seen++;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int lo, input int hi);
        DS = b;
        wait_cycles(lo);
        SH_CP   = 1'b1;
        m_shift = 16'((m_shift << 1) | {15'd0, b});
        m_cnt   = (m_cnt >= 17) ? 17 : m_cnt + 1;
        wait_cycles(hi);
        SH_CP = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] word, input int nbits, input int lo, input int hi);
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit(word[i], lo, hi);
        end
    endtask

    task automatic model_reset();
        m_shift = 16'h0000;
        m_cnt   = 0;
    endtask

    // Raises ST_CP (optionally together with an SH_CP edge carrying sim_ds) and checks the frame
    task automatic do_latch(input bit simul, input logic sim_ds,
                            input logic [15:0] e_par, input logic e_err);
        int  cycles;
        bit  got;
        if (simul) begin
            DS = sim_ds;
            wait_cycles(4);
            SH_CP   = 1'b1;
            ST_CP   = 1'b1;
            m_shift = 16'((m_shift << 1) | {15'd0, sim_ds});
            m_cnt   = 1;
        end else begin
            ST_CP = 1'b1;
            m_cnt = 0;
        end
        n_latch++;
        cycles = 0;
        got    = 1'b0;
        while (cycles < 10 && !got) begin
            @(negedge clk);
            cycles++;
            if (frame_valid) got = 1'b1;
        end
        check_output("frame_valid_seen", 32'(got), 32'd1);
        if (got) begin
            check_output("valid_latency", 32'(cycles), 32'd3);
            check_output("par_data", 32'(par_data), 32'(e_par));
            check_output("frame_err", 32'(frame_err), 32'(e_err));
            @(negedge clk);
            check_output("valid_width", 32'(frame_valid), 32'd0);
            check_output("err_width", 32'(frame_err), 32'd0);
        end
        wait_cycles(3);
        ST_CP = 1'b0;
        SH_CP = 1'b0;
        wait_cycles(4);
        check_output("bit_cnt_after_latch", 32'(bit_cnt), 32'(m_cnt));
    endtask

    initial begin
        logic [31:0] word;
        int          nbits;
        int          lo;
        int          hi;

        n_cmp        = 0;
        n_fail       = 0;
        n_latch      = 0;
        n_valid_seen = 0;
        model_reset();

        vec[0] = '{32'h0000A5C3, 16, 5'd16, 16'hA5C3, 1'b0};
        vec[1] = '{32'h00001234, 15, 5'd15, 16'h9234, 1'b1};
        vec[2] = '{32'h0002ABCD, 18, 5'd17, 16'hABCD, 1'b1};
        vec[3] = '{32'h00000000,  0, 5'd0,  16'hABCD, 1'b1};
        vec[4] = '{32'h00000000, 16, 5'd16, 16'h0000, 1'b0};
        vec[5] = '{32'h0000FFFF, 16, 5'd16, 16'hFFFF, 1'b0};

        rst_n = 1'b0;
        DS    = 1'b0;
        SH_CP = 1'b0;
        ST_CP = 1'b0;
        wait_cycles(5);
        check_output("rst_par_data", 32'(par_data), 32'd0);
        check_output("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        check_output("rst_frame_valid", 32'(frame_valid), 32'd0);
        check_output("rst_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        wait_cycles(3);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vec[i].data, vec[i].nbits, 4, 4);
            wait_cycles(4);
            check_output($sformatf("vec%0d_bit_cnt", i), 32'(bit_cnt), 32'(vec[i].exp_cnt));
            do_latch(1'b0, 1'b0, vec[i].exp_par, vec[i].exp_err);
        end

        // Same-edge shift and latch: latched word is the pre-shift value
        apply_stimulus(32'h0000FFFF, 16, 4, 4);
        wait_cycles(4);
        check_output("simul_pre_cnt", 32'(bit_cnt), 32'd16);
        do_latch(1'b1, 1'b0, 16'hFFFF, 1'b0);
        check_output("simul_bit_cnt", 32'(bit_cnt), 32'd1);

        apply_stimulus(32'h00000005, 3, 4, 4);
        wait_cycles(4);
        check_output("hold_par_data", 32'(par_data), 32'hFFFF);
        check_output("hold_bit_cnt", 32'(bit_cnt), 32'd4);

        // Reset in the middle of a frame
        apply_stimulus(32'h00000012, 8, 4, 4);
        rst_n = 1'b0;
        model_reset();
        wait_cycles(3);
        check_output("midrst_par_data", 32'(par_data), 32'd0);
        check_output("midrst_bit_cnt", 32'(bit_cnt), 32'd0);
        rst_n = 1'b1;
        wait_cycles(2);
        apply_stimulus(32'h000000FF, 16, 4, 4);
        wait_cycles(4);
        check_output("post_rst_cnt", 32'(bit_cnt), 32'd16);
        do_latch(1'b0, 1'b0, 16'h00FF, 1'b0);

        // SH_CP already high when reset releases counts as one shift
        rst_n = 1'b0;
        DS    = 1'b0;
        SH_CP = 1'b1;
        model_reset();
        wait_cycles(3);
        rst_n = 1'b1;
        m_shift = 16'h0000;
        m_cnt   = 1;
        wait_cycles(4);
        check_output("high_at_release_cnt", 32'(bit_cnt), 32'd1);
        SH_CP = 1'b0;
        wait_cycles(4);

        for (int f = 0; f < 25; f++) begin
            nbits = $urandom_range(0, 20);
            word  = $urandom;
            lo    = $urandom_range(2, 5);
            hi    = $urandom_range(2, 5);
            apply_stimulus(word, nbits, lo, hi);
            wait_cycles(4);
            check_output($sformatf("rnd%0d_bit_cnt", f), 32'(bit_cnt), 32'(m_cnt));
            if ($urandom_range(0, 3) == 0) begin
                do_latch(1'b1, 1'($urandom_range(0, 1)), m_shift, 1'(m_cnt != 16));
            end else begin
                do_latch(1'b0, 1'b0, m_shift, 1'(m_cnt != 16));
            end
        end

        wait_cycles(2);
        check_output("valid_pulse_count", 32'(n_valid_seen), 32'(n_latch));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hc595_rx.md
HC595_RX -- requirements
Module: hc595_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of bits per frame (sum of chained 74HC595 stages).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for all pin inputs (minimum 2).
REQ-003 clk  input  1  system clock, 50 MHz (20 ns period).
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 DS  input  1  serial data line, asynchronous to clk.
REQ-006 SH_CP  input  1  shift clock line, asynchronous to clk.
REQ-007 ST_CP  input  1  storage (latch) clock line, asynchronous to clk.
REQ-008 par_data  output  WIDTH  storage register contents, i.e. the last latched frame.
REQ-009 frame_valid  output  1  single-cycle pulse when par_data updates.
REQ-010 frame_err  output  1  single-cycle pulse, coincident with frame_valid, when the shift count since the previous latch is not WIDTH.
REQ-011 bit_cnt  output  clog2(WIDTH+2)  shifts since the last latch, saturating at WIDTH+1.

Function
REQ-012 DS, SH_CP and ST_CP SHALL each pass through SYNC_STAGES flops of identical depth so their relative alignment is preserved.
REQ-013 A rising edge on synchronized SH_CP SHALL shift: shift_reg <= {shift_reg[WIDTH-2:0], DS_sync}; the first bit sent ends in par_data[WIDTH-1] after WIDTH shifts.
REQ-014 Shift-register update latency SHALL be SYNC_STAGES+1 clk cycles from the SH_CP pin edge.
REQ-015 A rising edge on synchronized ST_CP SHALL copy shift_reg to par_data, pulse frame_valid for exactly one cycle, and clear bit_cnt to 0.
REQ-016 frame_valid latency SHALL be SYNC_STAGES+1 clk cycles from the ST_CP pin edge; par_data changes on the same cycle frame_valid is high.
REQ-017 Each SH_CP rising edge SHALL increment bit_cnt, saturating at WIDTH+1 (overrun indication).
REQ-018 frame_err SHALL be asserted with frame_valid iff bit_cnt != WIDTH at the latch edge (underrun, overrun, or a latch with zero shifts).
REQ-019 On simultaneous SH_CP and ST_CP detected edges, par_data SHALL load the pre-shift shift_reg value, the shift SHALL still occur, and bit_cnt SHALL become 1 (74HC595 semantics).
REQ-020 Falling edges on SH_CP and ST_CP SHALL have no effect.
REQ-021 Correct capture SHALL be guaranteed only when each SH_CP/ST_CP high and low level lasts at least 2 clk cycles and DS is stable from 1 cycle before to 1 cycle after the SH_CP rising edge; faster inputs are outside specification.
REQ-022 par_data SHALL hold its value indefinitely between latches, regardless of further shifting.

Reset
REQ-023 While rst_n is low: shift_reg, par_data and all synchronizer flops SHALL be 0; bit_cnt 0; frame_valid 0; frame_err 0.
REQ-024 Synchronizer and edge-detect history SHALL reset to 0, so an input already high at reset release produces one rising edge after SYNC_STAGES+1 cycles.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the next frame SHALL be received normally.

Structure
REQ-026 A shared package hc595_pkg SHALL hold the default WIDTH (16), the default SYNC_STAGES (2), and the bit_cnt width function, shared with the HC595 transmit side (dis_top).
REQ-027 A sub-module sync_rise (SYNC_STAGES synchronizer, then a registered rising-edge detect, outputting the synchronized level and a rise pulse) SHALL be instantiated for SH_CP and ST_CP; DS SHALL use a matching-depth synchronizer plus one alignment flop.

Verification
REQ-028 Send 16'hA5C3, MSB first (16 SH_CP pulses, 4 cycles/phase), then ST_CP -> par_data=16'hA5C3, one frame_valid pulse, frame_err=0, bit_cnt returns to 0.
REQ-029 Send 15 bits, then latch -> frame_valid=1, frame_err=1; send 18 bits, then latch -> frame_err=1, bit_cnt saturates at 17 before latch.
REQ-030 Raise SH_CP and ST_CP on the same clk edge after shifting 16'hFFFF then a 0 bit -> par_data=16'hFFFF, then bit_cnt=1.
REQ-031 Assert rst_n low after 8 bits of 16'h1234, release, send 16'h00FF and latch -> par_data=16'h00FF, frame_err=0, with no stale bits.
REQ-032 Connect to dis_top on a 50 MHz clk, release reset after 20 cycles, and run 500 cycles -> every ST_CP yields a frame_valid pulse with frame_err=0, and par_data matches the dis_top segment/select word.
